// File: rtl/spi_frame_monitor.sv
// Passive SPI bus monitor: oversamples the bus on pclk, captures MOSI/MISO words in any
// CPOL/CPHA mode and bit order, and queues them in a ready/valid FIFO with error flags.
module spi_frame_monitor #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned NUM_CS      = 1,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned IdxW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
    localparam int unsigned NbW  = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  pclk,
    input  logic                  areset,
    input  logic                  cfg_cpol,
    input  logic                  cfg_cpha,
    input  logic                  cfg_lsb_first,
    input  logic                  sclk,
    input  logic [NUM_CS-1:0]     cs_n,
    input  logic                  mosi,
    input  logic                  miso,
    output logic                  frm_valid,
    input  logic                  frm_ready,
    output logic [DATA_WIDTH-1:0] frm_mosi,
    output logic [DATA_WIDTH-1:0] frm_miso,
    output logic [IdxW-1:0]       frm_cs_idx,
    output logic [NbW-1:0]        frm_nbits,
    output logic                  frm_partial,
    output logic                  ovf_err,
    output logic                  cs_conflict,
    input  logic                  err_clr
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW = PtrW + 1;

    typedef enum logic [1:0] {StDiscard, StIdle, StActive} state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] mo;
        logic [DATA_WIDTH-1:0] mi;
        logic [IdxW-1:0]       idx;
        logic [NbW-1:0]        nb;
        logic                  part;
    } entry_t;

    logic [SYNC_STAGES-1:0]             sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0]             mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0]             miso_sync_q, miso_sync_d;
    logic [SYNC_STAGES-1:0][NUM_CS-1:0] cs_sync_q, cs_sync_d;
    logic                               sclk_prev_q, sclk_prev_d;

    state_e                state_q, state_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic                  fall_q, fall_d;
    logic                  lsb_q, lsb_d;
    logic [NbW-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] mo_sh_q, mo_sh_d, mi_sh_q, mi_sh_d;
    logic                  push_q, push_d;
    entry_t                push_ent_q, push_ent_d;

    entry_t                mem_q [FIFO_DEPTH];
    entry_t                mem_d [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]       level_q, level_d;
    logic                  ovf_q, ovf_d, conflict_q, conflict_d;

    logic                  sclk_s, mosi_s, miso_s, sample_edge;
    logic [NUM_CS-1:0]     cs_act, own_mask;
    logic [3:0]            n_act;
    logic [IdxW-1:0]       first_idx;
    logic                  conflict_set, ovf_set, pop, full, wr_en;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        miso_sync_d = {miso_sync_q[SYNC_STAGES-2:0], miso};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
        sclk_prev_d = sclk_sync_q[SYNC_STAGES-1];
        sclk_s      = sclk_sync_q[SYNC_STAGES-1];
        mosi_s      = mosi_sync_q[SYNC_STAGES-1];
        miso_s      = miso_sync_q[SYNC_STAGES-1];
        cs_act      = ~cs_sync_q[SYNC_STAGES-1];
        sample_edge = fall_q ? (~sclk_s & sclk_prev_q) : (sclk_s & ~sclk_prev_q);
        own_mask    = NUM_CS'(1) << idx_q;
        n_act       = '0;
        first_idx   = '0;
        for (int i = NUM_CS - 1; i >= 0; i--) begin
            n_act = n_act + 4'(cs_act[i]);
            if (cs_act[i]) first_idx = IdxW'(i);
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        fall_d       = fall_q;
        lsb_d        = lsb_q;
        cnt_d        = cnt_q;
        mo_sh_d      = mo_sh_q;
        mi_sh_d      = mi_sh_q;
        push_d       = 1'b0;
        push_ent_d   = push_ent_q;
        conflict_set = 1'b0;
        unique case (state_q)
            StDiscard: begin
                if (n_act == 4'd0) state_d = StIdle;
            end
            StIdle: begin
                if (n_act == 4'd1) begin
                    state_d = StActive;
                    idx_d   = first_idx;
                    fall_d  = cfg_cpol ^ cfg_cpha;
                    lsb_d   = cfg_lsb_first;
                    cnt_d   = '0;
                    mo_sh_d = '0;
                    mi_sh_d = '0;
                end else if (n_act > 4'd1) begin
                    state_d      = StDiscard;
                    conflict_set = 1'b1;
                end
            end
            StActive: begin
                if ((cs_act & ~own_mask) != '0) begin
                    state_d      = StDiscard;
                    conflict_set = 1'b1;
                end else begin
                    if (sample_edge) begin
                        if (lsb_q) begin
                            for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
                                if (cnt_q == NbW'(i)) begin
                                    mo_sh_d[i] = mosi_s;
                                    mi_sh_d[i] = miso_s;
                                end
                            end
                        end else begin
                            mo_sh_d = {mo_sh_q[DATA_WIDTH-2:0], mosi_s};
                            mi_sh_d = {mi_sh_q[DATA_WIDTH-2:0], miso_s};
                        end
                        cnt_d = cnt_q + NbW'(1);
                        if (cnt_d == NbW'(DATA_WIDTH)) begin
                            push_d     = 1'b1;
                            push_ent_d = '{mo: mo_sh_d, mi: mi_sh_d, idx: idx_q,
                                           nb: NbW'(DATA_WIDTH), part: 1'b0};
                            cnt_d      = '0;
                            // Clear so a following partial word stays right-justified.
                            mo_sh_d    = '0;
                            mi_sh_d    = '0;
                        end
                    end
                    // Release is evaluated after any same-cycle sample edge.
                    if ((cs_act & own_mask) == '0) begin
                        state_d = StIdle;
                        if (cnt_d != '0) begin
                            push_d     = 1'b1;
                            push_ent_d = '{mo: mo_sh_d, mi: mi_sh_d, idx: idx_q,
                                           nb: cnt_d, part: 1'b1};
                        end
                    end
                end
            end
            default: state_d = StDiscard;
        endcase
    end

    always_comb begin
        pop      = (level_q != '0) && frm_ready;
        full     = (level_q == LvlW'(FIFO_DEPTH));
        wr_en    = push_q && (!full || pop);
        ovf_set  = push_q && full && !pop;
        mem_d    = mem_q;
        if (wr_en) mem_d[wr_ptr_q] = push_ent_q;
        wr_ptr_d = wr_ptr_q + PtrW'(wr_en);
        rd_ptr_d = rd_ptr_q + PtrW'(pop);
        level_d  = level_q + LvlW'(wr_en) - LvlW'(pop);
        ovf_d      = ovf_set      ? 1'b1 : (err_clr ? 1'b0 : ovf_q);
        conflict_d = conflict_set ? 1'b1 : (err_clr ? 1'b0 : conflict_q);
    end

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            miso_sync_q <= '0;
            // Selects reset as asserted so DISCARD waits for a real all-high observation.
            cs_sync_q   <= '0;
            sclk_prev_q <= 1'b0;
            state_q     <= StDiscard;
            idx_q       <= '0;
            fall_q      <= 1'b0;
            lsb_q       <= 1'b0;
            cnt_q       <= '0;
            mo_sh_q     <= '0;
            mi_sh_q     <= '0;
            push_q      <= 1'b0;
            push_ent_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            ovf_q       <= 1'b0;
            conflict_q  <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            miso_sync_q <= miso_sync_d;
            cs_sync_q   <= cs_sync_d;
            sclk_prev_q <= sclk_prev_d;
            state_q     <= state_d;
            idx_q       <= idx_d;
            fall_q      <= fall_d;
            lsb_q       <= lsb_d;
            cnt_q       <= cnt_d;
            mo_sh_q     <= mo_sh_d;
            mi_sh_q     <= mi_sh_d;
            push_q      <= push_d;
            push_ent_q  <= push_ent_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            ovf_q       <= ovf_d;
            conflict_q  <= conflict_d;
        end
    end

    assign frm_valid   = (level_q != '0);
    assign frm_mosi    = mem_q[rd_ptr_q].mo;
    assign frm_miso    = mem_q[rd_ptr_q].mi;
    assign frm_cs_idx  = mem_q[rd_ptr_q].idx;
    assign frm_nbits   = mem_q[rd_ptr_q].nb;
    assign frm_partial = mem_q[rd_ptr_q].part;
    assign ovf_err     = ovf_q;
    assign cs_conflict = conflict_q;

endmodule

// File: tb/tb_spi_frame_monitor.sv
// Bench for spi_frame_monitor: table of single-CS frames plus hand sequences for overflow,
// select conflict and mid-frame reset; words are checked through an expected/observed queue.
module tb_spi_frame_monitor;

    localparam int H = 40;

    typedef struct packed {
        logic [7:0] mo;
        logic [7:0] mi;
        logic [0:0] idx;
        logic [3:0] nb;
        logic       part;
    } word_t;

    // Field order: cpol cpha lsb wrong nb tm0 tm1 ts0 ts1 nexp em0 em1 es0 es1 enb epart
    typedef struct {
        bit         cpol, cpha, lsb, wrong;
        int         nb;
        logic [7:0] tm0, tm1, ts0, ts1;
        int         nexp;
        logic [7:0] em0, em1, es0, es1;
        int         enb;
        bit         epart;
    } vec_t;

    logic       pclk = 1'b0;
    logic       areset = 1'b0;
    logic       cfg_cpol = 1'b0, cfg_cpha = 1'b0, cfg_lsb_first = 1'b0;
    logic       sclk = 1'b0;
    logic [1:0] cs_n = 2'b11;
    logic       mosi = 1'b0, miso = 1'b0;
    logic       frm_valid;
    logic       frm_ready = 1'b1;
    logic [7:0] frm_mosi, frm_miso;
    logic [0:0] frm_cs_idx;
    logic [3:0] frm_nbits;
    logic       frm_partial, ovf_err, cs_conflict;
    logic       err_clr = 1'b0;

    int    n_checks = 0;
    int    n_errors = 0;
    word_t exp_q[$];
    word_t obs_q[$];
    vec_t  vecs[8];

    spi_frame_monitor #(
        .DATA_WIDTH (8),
        .NUM_CS     (2),
        .FIFO_DEPTH (4),
        .SYNC_STAGES(2)
    ) dut (
        .pclk         (pclk),
        .areset       (areset),
        .cfg_cpol     (cfg_cpol),
        .cfg_cpha     (cfg_cpha),
        .cfg_lsb_first(cfg_lsb_first),
        .sclk         (sclk),
        .cs_n         (cs_n),
        .mosi         (mosi),
        .miso         (miso),
        .frm_valid    (frm_valid),
        .frm_ready    (frm_ready),
        .frm_mosi     (frm_mosi),
        .frm_miso     (frm_miso),
        .frm_cs_idx   (frm_cs_idx),
        .frm_nbits    (frm_nbits),
        .frm_partial  (frm_partial),
        .ovf_err      (ovf_err),
        .cs_conflict  (cs_conflict),
        .err_clr      (err_clr)
    );

    always #5 pclk = ~pclk;

    always @(negedge pclk) begin
        if (areset && frm_valid && frm_ready)
            obs_q.push_back({frm_mosi, frm_miso, frm_cs_idx, frm_nbits, frm_partial});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ser(input logic [7:0] w, input int n, input bit lsb);
        logic [63:0] s;
        s = '0;
        for (int j = 0; j < n; j++) s[j] = lsb ? w[j] : w[n-1-j];
        return s;
    endfunction

    task automatic cs_low(input int cs);
        cs_n[cs] = 1'b0;
        #H;
    endtask

    // Normal mode launches on the non-sampling edge; 'wrong' launches each next bit on the
    // sampling edge itself, so every sample sees the following bit.
    task automatic shift_bits(input bit cpha, input bit wrong, input int n,
                              input logic [63:0] mo, input logic [63:0] mi);
        if (wrong) begin
            mosi = mo[0];
            miso = mi[0];
        end
        for (int i = 0; i < n; i++) begin
            if (!wrong) begin
                if (!cpha) begin
                    mosi = mo[i]; miso = mi[i];
                    #H; sclk = ~sclk; #H; sclk = ~sclk;
                end else begin
                    sclk = ~sclk; mosi = mo[i]; miso = mi[i];
                    #H; sclk = ~sclk; #H;
                end
            end else begin
                if (!cpha) begin
                    #H; sclk = ~sclk;
                    mosi = (i + 1 < n) ? mo[i+1] : 1'b0;
                    miso = (i + 1 < n) ? mi[i+1] : 1'b0;
                    #H; sclk = ~sclk;
                end else begin
                    sclk = ~sclk; #H; sclk = ~sclk;
                    mosi = (i + 1 < n) ? mo[i+1] : 1'b0;
                    miso = (i + 1 < n) ? mi[i+1] : 1'b0;
                    #H;
                end
            end
        end
    endtask

    task automatic send_frame(input int cs, input bit cpha, input bit wrong, input int n,
                              input logic [63:0] mo, input logic [63:0] mi);
        cs_low(cs);
        shift_bits(cpha, wrong, n, mo, mi);
        #H;
        cs_n[cs] = 1'b1;
        #(H * 2);
    endtask

    task automatic set_mode(input bit cpol, input bit cpha, input bit lsb);
        cfg_cpol = cpol;
        cfg_cpha = cpha;
        cfg_lsb_first = lsb;
        sclk = cpol;
        #(H * 2);
    endtask

    task automatic pulse_clr();
        @(posedge pclk); #2 err_clr = 1'b1;
        @(posedge pclk); #2 err_clr = 1'b0;
    endtask

    task automatic check_sb(input string name);
        int    budget;
        word_t e, o;
        budget = 0;
        while (obs_q.size() < exp_q.size() && budget < 300) begin
            @(negedge pclk);
            budget++;
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL %s: got no word, required %h", name, e);
            end else begin
                o = obs_q.pop_front();
                chk(name, 64'(o), 64'(e));
            end
        end
        chk({name, "_extra_words"}, 64'(obs_q.size()), 64'd0);
        obs_q.delete();
    endtask

    initial begin
        logic [63:0] mo, mi;
        vec_t        v;

        vecs[0] = '{0,0,0,0,  8, 8'hA5,8'h00,8'h3C,8'h00, 1, 8'hA5,8'h00,8'h3C,8'h00, 8, 0};
        vecs[1] = '{0,1,1,0, 16, 8'h81,8'h7E,8'h7E,8'h81, 2, 8'h81,8'h7E,8'h7E,8'h81, 8, 0};
        vecs[2] = '{1,0,1,0, 16, 8'h81,8'h7E,8'h7E,8'h81, 2, 8'h81,8'h7E,8'h7E,8'h81, 8, 0};
        vecs[3] = '{1,1,1,0, 16, 8'h81,8'h7E,8'h7E,8'h81, 2, 8'h81,8'h7E,8'h7E,8'h81, 8, 0};
        vecs[4] = '{0,0,0,0,  5, 8'h16,8'h00,8'h09,8'h00, 1, 8'h16,8'h00,8'h09,8'h00, 5, 1};
        vecs[5] = '{1,1,1,0,  3, 8'h05,8'h00,8'h02,8'h00, 1, 8'h05,8'h00,8'h02,8'h00, 3, 1};
        vecs[6] = '{0,1,1,1,  8, 8'h81,8'h00,8'h7E,8'h00, 1, 8'h40,8'h00,8'h3F,8'h00, 8, 0};
        vecs[7] = '{0,0,0,1,  8, 8'hA5,8'h00,8'h3C,8'h00, 1, 8'h4A,8'h00,8'h78,8'h00, 8, 0};

        #12;
        chk("rst_valid",    64'(frm_valid),   64'd0);
        chk("rst_mosi",     64'(frm_mosi),    64'd0);
        chk("rst_miso",     64'(frm_miso),    64'd0);
        chk("rst_cs_idx",   64'(frm_cs_idx),  64'd0);
        chk("rst_nbits",    64'(frm_nbits),   64'd0);
        chk("rst_partial",  64'(frm_partial), 64'd0);
        chk("rst_ovf",      64'(ovf_err),     64'd0);
        chk("rst_conflict", 64'(cs_conflict), 64'd0);
        #20 areset = 1'b1;
        @(posedge pclk); #2;
        #(H * 2);

        for (int i = 0; i < 8; i++) begin
            v = vecs[i];
            set_mode(v.cpol, v.cpha, v.lsb);
            if (v.nb <= 8) begin
                mo = ser(v.tm0, v.nb, v.lsb);
                mi = ser(v.ts0, v.nb, v.lsb);
            end else begin
                mo = ser(v.tm0, 8, v.lsb) | (ser(v.tm1, 8, v.lsb) << 8);
                mi = ser(v.ts0, 8, v.lsb) | (ser(v.ts1, 8, v.lsb) << 8);
            end
            exp_q.push_back({v.em0, v.es0, 1'b0, 4'(v.enb), v.epart});
            if (v.nexp == 2) exp_q.push_back({v.em1, v.es1, 1'b0, 4'(v.enb), v.epart});
            send_frame(0, v.cpha, v.wrong, v.nb, mo, mi);
            check_sb($sformatf("vec%0d", i));
        end

        // Overflow: five words into a four-entry FIFO with the consumer stalled.
        set_mode(0, 0, 0);
        frm_ready = 1'b0;
        mo = '0;
        mi = '0;
        for (int k = 0; k < 5; k++) begin
            mo |= ser(8'(8'h11 * (k + 1)), 8, 0) << (8 * k);
            mi |= ser(8'(8'hEE - 8'h11 * k), 8, 0) << (8 * k);
        end
        for (int k = 0; k < 4; k++)
            exp_q.push_back({8'(8'h11 * (k + 1)), 8'(8'hEE - 8'h11 * k), 1'b0, 4'd8, 1'b0});
        send_frame(0, 0, 0, 40, mo, mi);
        chk("ovf_set", 64'(ovf_err), 64'd1);
        chk("ovf_head", 64'({frm_valid, frm_mosi, frm_miso}), {47'd0, 1'b1, 8'h11, 8'hEE});
        #(H * 2);
        chk("ovf_head_stable", 64'({frm_valid, frm_mosi, frm_miso}), {47'd0, 1'b1, 8'h11, 8'hEE});
        frm_ready = 1'b1;
        check_sb("ovf_words");
        pulse_clr();
        chk("ovf_clear", 64'(ovf_err), 64'd0);

        // Second select asserts mid-frame: nothing pushed, conflict flagged.
        cs_low(0);
        shift_bits(0, 0, 3, 64'h5, 64'h2);
        cs_n[1] = 1'b0;
        #(H * 2);
        chk("conflict_set", 64'(cs_conflict), 64'd1);
        chk("conflict_no_valid", 64'(frm_valid), 64'd0);
        cs_n = 2'b11;
        #(H * 2);
        check_sb("conflict_drop");
        exp_q.push_back({8'hC3, 8'h5A, 1'b1, 4'd8, 1'b0});
        send_frame(1, 0, 0, 8, ser(8'hC3, 8, 0), ser(8'h5A, 8, 0));
        check_sb("cs1_resume");
        pulse_clr();
        chk("conflict_clear", 64'(cs_conflict), 64'd0);

        // Reset in the middle of a byte; the tail must not form a word.
        cs_low(0);
        shift_bits(0, 0, 4, ser(8'hF0, 8, 0), ser(8'h0F, 8, 0));
        areset = 1'b0;
        #10;
        chk("midrst_valid", 64'(frm_valid), 64'd0);
        areset = 1'b1;
        shift_bits(0, 0, 4, 64'h0, 64'hF);
        #H;
        cs_n[0] = 1'b1;
        #(H * 2);
        check_sb("midrst_tail");
        exp_q.push_back({8'h96, 8'h69, 1'b0, 4'd8, 1'b0});
        send_frame(0, 0, 0, 8, ser(8'h96, 8, 0), ser(8'h69, 8, 0));
        check_sb("midrst_next");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_frame_monitor.md
# spi_frame_monitor

Synthesizable passive SPI bus monitor: the parametrised successor of the master monitor BFM's per-mode MISO sampling tasks. Oversamples SCLK/CS_n/MOSI/MISO on the system clock. Captures MOSI and MISO words in all four CPOL/CPHA modes, MSB- or LSB-first, across multiple chip selects. Completed words go to a ready/valid FIFO, alongside partial-frame, overflow and CS-conflict reporting. Sits beside the SPI interface in hdl_top as a checker/coverage source and as a silicon-reusable debug tap.

## Interface
- DATA_WIDTH, 8, bits per word (2..32)
- NUM_CS, 1, number of chip-select lines (1..8)
- FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2)
- SYNC_STAGES, 2, synchronizer flops on sclk/cs_n/mosi/miso (>=2)

Ports:
- pclk  in  1  system clock; must be >= 4x SCLK frequency
- areset  in  1  asynchronous, active-low reset
- cfg_cpol  in  1  SCLK idle level
- cfg_cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
- cfg_lsb_first  in  1  bit order
- sclk  in  1  SPI clock (async)
- cs_n  in  NUM_CS  active-low selects (async)
- mosi, miso  in  1  serial data (async)
- frm_valid  out  1  FIFO head valid
- frm_ready  in  1  consumer accept
- frm_mosi, frm_miso  out  DATA_WIDTH  captured words
- frm_cs_idx  out  max(1,$clog2(NUM_CS))  select index of the word
- frm_nbits  out  $clog2(DATA_WIDTH+1)  bits captured (DATA_WIDTH unless partial)
- frm_partial  out  1  word ended early by CS release
- ovf_err  out  1  sticky: word dropped on full FIFO
- cs_conflict  out  1  sticky: >1 select active simultaneously
- err_clr  in  1  synchronous clear of both sticky flags

## Operation
- All async inputs pass through SYNC_STAGES flops. One extra flop on synced sclk gives edge detect.
- Sample edge: rising if cfg_cpol XOR cfg_cpha = 0, else falling. The opposite edge is ignored.
- cfg_* are latched at frame start (IDLE->ACTIVE). Changes mid-frame take effect at the next frame.
- FSM states:
  - DISCARD is the reset state. Exits to IDLE when all synced cs_n are high.
  - IDLE -> ACTIVE when exactly one cs_n goes low. The index is latched, and the bit counter and shift registers are cleared.
  - IDLE -> DISCARD (set cs_conflict) when >1 cs_n goes low.
  - ACTIVE: on each sample edge, capture mosi and miso, and increment the counter.
    - MSB-first: shift left, inserting at bit 0.
    - LSB-first: write bit[count].
    - When count reaches DATA_WIDTH, push a full word (nbits=DATA_WIDTH, partial=0), reset the counter and stay ACTIVE (back-to-back words).
  - ACTIVE -> IDLE when the latched cs_n deasserts. If count>0, push a partial word (nbits=count, partial=1) with received bits right-justified: first bit at bit0 for LSB-first, last bit at bit0 for MSB-first.
  - ACTIVE -> DISCARD (set cs_conflict, drop the in-progress bits) when any other cs_n asserts.
- A sample edge and CS release in the same pclk cycle: the edge is captured first, then the release is processed, giving one push only.
- FIFO rules:
  - Push when full: the word is dropped and ovf_err is set, unless frm_ready && frm_valid in that cycle, in which case the push is accepted.
  - Pop on frm_valid && frm_ready.
  - Empty plus push: valid the next cycle (no fall-through).
- Sticky flags: err_clr clears them. Set wins over clear in the same cycle.

## Timing
- Reset values: frm_valid=0, frm_mosi=frm_miso=0, frm_cs_idx=0, frm_nbits=0, frm_partial=0, ovf_err=0, cs_conflict=0; FSM=DISCARD; FIFO empty.
- Latency: a raw SCLK sample edge is detected SYNC_STAGES+1 pclk edges later. The word is written into the FIFO on the following edge, so frm_valid is high SYNC_STAGES+2 cycles after the last sample edge.
- Partial word: frm_valid rises SYNC_STAGES+2 cycles after cs_n rises.
- FIFO throughput: one push and one pop per cycle.
- frm_* outputs are stable while frm_valid && !frm_ready.
- Reset mid-frame: all state is cleared asynchronously. Capture restarts only after all cs_n have been high (DISCARD).

## Test plan
- **Mode 0, MSB-first, DATA_WIDTH=8, frm_ready=1:** MOSI 0xA5, MISO 0x3C on cs_n[0] -> one word: mosi=0xA5, miso=0x3C, nbits=8, partial=0, cs_idx=0.
- **Modes 1/2/3 LSB-first:** byte 0x81 then 0x7E, back-to-back under one CS -> two words in order, each decoded correctly per mode. Driving data on the wrong edge yields mismatches (negative check).
- **Partial frame, MSB-first:** CS released after 5 bits 1,0,1,1,0 -> nbits=5, partial=1, word=0x16.
- **Overflow, FIFO_DEPTH=4, frm_ready=0:** send 5 bytes -> first 4 retained in order, 5th dropped, ovf_err=1. err_clr -> ovf_err=0.
- **NUM_CS=2:** cs_n[1] asserts during an active cs_n[0] frame -> cs_conflict=1, no word pushed; capture resumes after both release.
- **areset pulse mid-byte:** after reset, remaining bits produce no word until CS cycles high-low. The next full byte is captured correctly.
